// File: rtl/uart_tx_pkg.sv
// uart_tx_pkg: shared FSM encoding and default parameters for the UART transmit path
package uart_tx_pkg;
  typedef enum logic [1:0] {IDLE = 2'd0, START = 2'd1, DATA = 2'd2, STOP = 2'd3} state_t;
  localparam int OVERSAMPLE = 16;
  localparam int D_BIT_DEF = 8;
  localparam int STOP_TICK_DEF = 32;
  localparam int DEPTH_DEF = 8;
  localparam int CNT_W_DEF = 10;
endpackage

// File: rtl/uart_tx_fifo.sv
// uart_tx_fifo: first-word-fall-through FIFO with registered full/empty flags
module uart_tx_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en,
  input  logic [WIDTH-1:0] data_in,
  input  logic             read_en,
  output logic [WIDTH-1:0] data_out,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  logic [WIDTH-1:0] mem [DEPTH];
  logic [AW-1:0] wr_ptr, rd_ptr;
  logic [AW:0] count, count_nx;
  logic wr, rd;
  assign wr = write_en && !full;
  assign rd = read_en && !empty;
  assign count_nx = count + {{AW{1'b0}}, wr} - {{AW{1'b0}}, rd};
  assign data_out = mem[rd_ptr];
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count <= '0;
      full <= 1'b0;
      empty <= 1'b1;
    end else begin
      if (wr) mem[wr_ptr] <= data_in;
      if (wr) wr_ptr <= wr_ptr + 1'b1;
      if (rd) rd_ptr <= rd_ptr + 1'b1;
      count <= count_nx;
      full <= count_nx == FULL_CNT;
      empty <= count_nx == '0;
    end
  end
endmodule

// File: rtl/uart_tx_path.sv
// uart_tx_path: FIFO-buffered UART transmitter with internal baud tick generator
module uart_tx_path
  import uart_tx_pkg::*;
#(
  parameter int D_BIT = D_BIT_DEF,
  parameter int STOP_TICK = STOP_TICK_DEF,
  parameter int DEPTH = DEPTH_DEF,
  parameter int CNT_W = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             write_en,
  input  logic [D_BIT-1:0] write_data,
  output logic             full,
  output logic             empty,
  input  logic [CNT_W-1:0] input_number,
  output logic             tx,
  output logic             tx_busy,
  output logic             tx_done
);
  localparam int SW = STOP_TICK > OVERSAMPLE ? $clog2(STOP_TICK) : 4;
  localparam int NW = D_BIT > 1 ? $clog2(D_BIT) : 1;
  logic [CNT_W-1:0] cnt;
  logic s_tick;
  state_t state, state_nx;
  logic [SW-1:0] s_cnt, s_cnt_nx;
  logic [NW-1:0] n, n_nx;
  logic [D_BIT-1:0] shreg, shreg_nx, head;
  logic pop, done_nx, tx_nx;
  uart_tx_fifo #(.WIDTH(D_BIT), .DEPTH(DEPTH)) u_fifo (
    .clk(clk), .rst(rst), .write_en(write_en), .data_in(write_data),
    .read_en(pop), .data_out(head), .full(full), .empty(empty)
  );
  // A zero divisor parks the counter so the FSM stalls with tx held
  assign s_tick = (input_number != '0) && (cnt == input_number - CNT_W'(1));
  always_ff @(posedge clk)
    cnt <= (rst || s_tick || input_number == '0) ? '0 : cnt + 1'b1;
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
      s_cnt <= '0;
      n <= '0;
      shreg <= '0;
      tx <= 1'b1;
      tx_done <= 1'b0;
    end else begin
      state <= state_nx;
      s_cnt <= s_cnt_nx;
      n <= n_nx;
      shreg <= shreg_nx;
      tx <= tx_nx;
      tx_done <= done_nx;
    end
  end
  always_comb begin
    state_nx = state;
    s_cnt_nx = s_cnt;
    n_nx = n;
    shreg_nx = shreg;
    pop = 1'b0;
    done_nx = 1'b0;
    case (state)
      IDLE: if (!empty) begin
        pop = 1'b1;
        shreg_nx = head;
        s_cnt_nx = '0;
        state_nx = START;
      end
      START: if (s_tick) begin
        s_cnt_nx = s_cnt == SW'(OVERSAMPLE-1) ? '0 : s_cnt + 1'b1;
        if (s_cnt == SW'(OVERSAMPLE-1)) begin
          n_nx = '0;
          state_nx = DATA;
        end
      end
      DATA: if (s_tick) begin
        s_cnt_nx = s_cnt == SW'(OVERSAMPLE-1) ? '0 : s_cnt + 1'b1;
        if (s_cnt == SW'(OVERSAMPLE-1)) begin
          shreg_nx = shreg >> 1;
          n_nx = n == NW'(D_BIT-1) ? n : n + 1'b1;
          state_nx = n == NW'(D_BIT-1) ? STOP : DATA;
        end
      end
      STOP: if (s_tick) begin
        s_cnt_nx = s_cnt == SW'(STOP_TICK-1) ? '0 : s_cnt + 1'b1;
        done_nx = s_cnt == SW'(STOP_TICK-1);
        state_nx = s_cnt == SW'(STOP_TICK-1) ? IDLE : STOP;
      end
      default: state_nx = IDLE;
    endcase
  end
  // tx is precomputed from the next state so the line comes straight off a flop
  always_comb tx_nx = state_nx == START ? 1'b0 : state_nx == DATA ? shreg_nx[0] : 1'b1;
  assign tx_busy = state != IDLE;
endmodule

// File: tb/tb_uart_tx_path.sv
// tb_uart_tx_path: scoreboard bench; a mid-bit sampling UART monitor decodes tx against queued bytes
module tb_uart_tx_path;
  logic clk = 0, rst = 1, write_en = 0;
  logic [7:0] write_data = 0;
  logic [9:0] input_number = 10'd4;
  logic full, empty, tx, tx_busy, tx_done;
  int total = 0, bad = 0;
  logic [7:0] expq[$];
  bit mon_en = 0;

  uart_tx_path dut (
    .clk(clk), .rst(rst), .write_en(write_en), .write_data(write_data), .full(full),
    .empty(empty), .input_number(input_number), .tx(tx), .tx_busy(tx_busy), .tx_done(tx_done)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input int act, input int req);
    total++;
    if (act != req) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", nm, act, req);
    end
  endtask

  task automatic wait_done(input string nm);
    int k;
    @(negedge clk);
    k = 0;
    while (!tx_done && k < 5000) begin
      @(negedge clk);
      k++;
    end
    if (!tx_done) begin
      total++;
      bad++;
      $display("FAIL %s: got timeout expected tx_done", nm);
    end
  endtask

  task automatic put(input logic [7:0] d);
    @(negedge clk);
    write_en = 1;
    write_data = d;
    @(negedge clk);
    write_en = 0;
  endtask

  // Behavioural receiver: after the falling start edge, sample each bit in its middle
  initial begin
    logic prev;
    logic [7:0] b;
    int nb;
    prev = 1;
    forever begin
      @(negedge clk);
      if (mon_en && prev && !tx) begin
        while (input_number == 0) @(negedge clk);
        nb = int'(input_number);
        repeat (8 * nb) @(negedge clk);
        chk("mon_start", tx, 0);
        for (int i = 0; i < 8; i++) begin
          repeat (16 * nb) @(negedge clk);
          b[i] = tx;
        end
        repeat (16 * nb) @(negedge clk);
        chk("mon_stop1", tx, 1);
        repeat (4 * nb) @(negedge clk);
        chk("mon_stop2", tx, 1);
        total++;
        if (expq.size() == 0) begin
          bad++;
          $display("FAIL mon_data: got 0x%02h expected no frame", b);
        end else if (b != expq[0]) begin
          bad++;
          $display("FAIL mon_data: got 0x%02h expected 0x%02h", b, expq[0]);
          void'(expq.pop_front());
        end else void'(expq.pop_front());
      end
      prev = tx;
    end
  end

  initial begin
    int s, t, lows;
    logic [7:0] r;
    repeat (3) @(negedge clk);
    chk("rst_tx", tx, 1);
    chk("rst_empty", empty, 1);
    chk("rst_full", full, 0);
    chk("rst_busy", tx_busy, 0);
    chk("rst_done", tx_done, 0);
    rst = 0;
    // Reset mid-frame with bytes still queued
    for (int i = 0; i < 3; i++) put(8'h5A + 8'(i));
    repeat (200) @(negedge clk);
    chk("t1_busy_before", tx_busy, 1);
    rst = 1;
    @(negedge clk);
    chk("t1_tx", tx, 1);
    chk("t1_empty", empty, 1);
    chk("t1_full", full, 0);
    chk("t1_busy", tx_busy, 0);
    repeat (2) @(negedge clk);
    rst = 0;
    lows = 0;
    repeat (1000) begin
      @(negedge clk);
      if (!tx || tx_busy) lows++;
    end
    chk("t1_quiet", lows, 0);
    mon_en = 1;
    // Single frame with timing measurement
    expq.push_back(8'hA5);
    put(8'hA5);
    t = 0;
    while (tx && t < 20) begin
      @(negedge clk);
      t++;
    end
    chk("t2_start_seen", tx, 0);
    s = 0;
    while (!tx && s < 200) begin
      s++;
      @(negedge clk);
    end
    chk("t2_start_len_in_range", int'(s >= 61 && s <= 67), 1);
    t = s;
    while (!tx_done && t < 2000) begin
      t++;
      @(negedge clk);
    end
    chk("t2_data_plus_stop_len", t - s, 8 * 64 + 128);
    chk("t2_idle_at_done", tx_busy, 0);
    @(negedge clk);
    chk("t2_done_pulse", tx_done, 0);
    repeat (5) @(negedge clk);
    chk("t2_queue_drained", expq.size(), 0);
    // Burst of 10 writes: the first drains at once, so 9 fit and the last is dropped
    for (int i = 1; i <= 10; i++) begin
      @(negedge clk);
      if (i == 9) chk("t3_not_full_before_9th", full, 0);
      if (i == 10) chk("t3_full_after_9th", full, 1);
      write_en = 1;
      write_data = 8'(i);
      if (i <= 9) expq.push_back(8'(i));
    end
    @(negedge clk);
    write_en = 0;
    for (int f = 0; f < 9; f++) begin
      wait_done("t3_done");
      chk("t3_idle_tx", tx, 1);
      if (f < 8) begin
        @(negedge clk);
        chk("t3_one_idle_gap", tx, 0);
      end
    end
    @(negedge clk);
    chk("t3_empty", empty, 1);
    chk("t3_queue_drained", expq.size(), 0);
    // Write on the pop cycle while full is dropped
    for (int i = 0; i < 9; i++) begin
      @(negedge clk);
      r = 8'($urandom);
      write_en = 1;
      write_data = r;
      expq.push_back(r);
    end
    @(negedge clk);
    write_en = 0;
    chk("t5_full", full, 1);
    wait_done("t5_first_done");
    chk("t5_full_at_pop", full, 1);
    write_en = 1;
    write_data = 8'hEE;
    @(negedge clk);
    write_en = 0;
    chk("t5_full_after_pop", full, 0);
    chk("t5_not_empty", empty, 0);
    for (int f = 0; f < 8; f++) wait_done("t5_done");
    @(negedge clk);
    chk("t5_empty", empty, 1);
    chk("t5_queue_drained", expq.size(), 0);
    // Zero divisor stalls in the start bit until a divisor is given
    @(negedge clk);
    input_number = 0;
    repeat (5) @(negedge clk);
    expq.push_back(8'h3C);
    put(8'h3C);
    repeat (10) @(negedge clk);
    chk("t4_stall_tx", tx, 0);
    chk("t4_stall_busy", tx_busy, 1);
    lows = 0;
    repeat (300) begin
      @(negedge clk);
      if (tx) lows++;
    end
    chk("t4_stall_held", lows, 0);
    input_number = 2;
    wait_done("t4_done");
    chk("t4_queue_drained", expq.size(), 0);
    // Pointer wrap: 20 random bytes one per frame, divisor only ever rises
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      input_number = 10'(2 + i / 5);
      r = 8'($urandom);
      expq.push_back(r);
      put(r);
      wait_done("t6_done");
    end
    @(negedge clk);
    chk("t6_empty", empty, 1);
    chk("t6_queue_drained", expq.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
